uart_transmitter: RTL

Serial transmit end of the host link. It consumes the `write`/`tx_data` byte stream from `keyboard_controller` and drives the FPGA-to-host UART line as asynchronous 8-bit frames with optional parity. It returns the `busy` flag that `keyboard_controller` already samples before it issues a `write`. It runs on the single 50 MHz system clock with a synchronous, active-high reset.

---
 rtl/uart_transmitter.sv | 111 +++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmit FSM, 8 data bits, optional parity
// Registered tx/busy; the byte is latched at accept so later tx_data changes are ignored.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       tx
);

  localparam int          CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam bit          PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam logic        PAR_ODD = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            par_bit;
  logic            bit_end;

  assign bit_end = (baud_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (write) begin
            shift_reg <= tx_data;
            par_bit   <= (^tx_data) ^ PAR_ODD;
            baud_cnt  <= '0;
            tx        <= 1'b0;
            busy      <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift_reg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              if (PAR_EN) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              // tx picks up bit 1 now because shift_reg only shifts at this same edge
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            tx       <= 1'b1;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
